// File: rtl/tx_fifo_pkg.sv
// Shared constants and helpers for the TX data FIFO.
package tx_fifo_pkg;

    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_AW = 10;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/tx_fifo_sdp_ram.sv
// Simple-dual-port storage: one write port, one read port, registered read, no forwarding.
module tx_fifo_sdp_ram
    import tx_fifo_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // No reset so the array and read register map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tx_data_fifo_sync.sv
// Single-clock TX data FIFO: pointer/level/flag control around an SDP RAM,
// with standard or first-word-fall-through read behaviour.
module tx_data_fifo_sync
    import tx_fifo_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int AW        = DEFAULT_AW,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = (1 << AW) - 4,
    parameter int AE_THRESH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    localparam int            PW      = clog2(1 << AW) + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(1 << AW);
    localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic          full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic          ovf_q, ovf_d, udf_q, udf_d, rvld_q, rvld_d, has_q, has_d;
    logic          mid_q, mid_d, ovld_q, ovld_d;
    logic [DW-1:0] out_q, out_d, ram_rdata;
    logic          wr_acc, pop, fetch, load_out, ram_ne;

    tx_fifo_sdp_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wr_data),
        .re    (fetch),
        .raddr (rptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_acc = wr_en && !full_q && !flush;
        pop    = rd_en && !empty_q && !flush;
        ram_ne = (wptr_q != rptr_q);

        // FWFT keeps two stages: RAM read register (mid) feeding the output register.
        if (FWFT == FIFO_FWFT) begin
            load_out = mid_q && (!ovld_q || pop) && !flush;
            fetch    = ram_ne && (!mid_q || load_out) && !flush;
        end else begin
            load_out = 1'b0;
            fetch    = pop;
        end

        wptr_d  = wptr_q + {{(PW-1){1'b0}}, wr_acc};
        rptr_d  = rptr_q + {{(PW-1){1'b0}}, fetch};
        level_d = level_q;
        if (wr_acc && !pop)      level_d = level_q + 1'b1;
        else if (!wr_acc && pop) level_d = level_q - 1'b1;

        mid_d  = fetch || (mid_q && !load_out);
        ovld_d = load_out || (ovld_q && !pop);
        out_d  = load_out ? ram_rdata : out_q;
        has_d  = has_q || pop;
        rvld_d = pop;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            mid_d   = 1'b0;
            ovld_d  = 1'b0;
            rvld_d  = 1'b0;
        end

        // Full tracks the held-word count so FWFT staging words also count as occupied.
        full_d  = (level_d == DEPTH_L);
        empty_d = (FWFT == FIFO_FWFT) ? !ovld_d : (level_d == '0);
        af_d    = (level_d >= AF_L);
        ae_d    = (level_d <= AE_L);

        ovf_d = (wr_en && full_q)  || (ovf_q && !clr_err);
        udf_d = (rd_en && empty_q) || (udf_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rvld_q  <= 1'b0;
            has_q   <= 1'b0;
            mid_q   <= 1'b0;
            ovld_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            rvld_q  <= rvld_d;
            has_q   <= has_d;
            mid_q   <= mid_d;
            ovld_q  <= ovld_d;
            out_q   <= out_d;
        end
    end

    // In standard mode the RAM read register is the output; mask it until a word has been read.
    assign rd_data      = (FWFT == FIFO_FWFT) ? out_q : (has_q ? ram_rdata : '0);
    assign rd_valid     = (FWFT == FIFO_FWFT) ? ovld_q : rvld_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_tx_data_fifo_sync.sv
// Directed bench for tx_data_fifo_sync: a standard-mode instance checked every cycle
// against a level/flag model and data scoreboard, plus an FWFT instance.
module tb_tx_data_fifo_sync;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        s_flush, s_wr_en, s_rd_en, s_clr_err;
    logic [31:0] s_wr_data, s_rd_data;
    logic        s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [10:0] s_level;

    logic        f_flush, f_wr_en, f_rd_en, f_clr_err;
    logic [31:0] f_wr_data, f_rd_data;
    logic        f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [10:0] f_level;

    tx_data_fifo_sync #(.DW(32), .AW(10), .FWFT(0)) u_std (
        .clk(clk), .rstn(rstn), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(s_clr_err)
    );

    tx_data_fifo_sync #(.DW(32), .AW(10), .FWFT(1)) u_fwft (
        .clk(clk), .rstn(rstn), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];
    logic [31:0] fq[$];
    int          m_lvl;
    logic        m_ovf, m_udf;
    logic [31:0] m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the standard instance; the model predicts the state right after the edge.
    task automatic step(input logic we, input logic [31:0] wd, input logic re,
                        input logic fl, input logic clr);
        logic wr_ok, rd_ok;
        wr_ok = we && !fl && (m_lvl < DEPTH);
        rd_ok = re && !fl && (m_lvl > 0);
        m_ovf = (we && m_lvl == DEPTH) || (m_ovf && !clr);
        m_udf = (re && m_lvl == 0) || (m_udf && !clr);
        if (rd_ok) m_last = sb.pop_front();
        if (wr_ok) sb.push_back(wd);
        m_lvl = m_lvl + int'(wr_ok) - int'(rd_ok);
        if (fl) begin
            sb.delete();
            m_lvl = 0;
        end
        s_wr_en = we; s_wr_data = wd; s_rd_en = re; s_flush = fl; s_clr_err = clr;
        @(posedge clk);
        #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_flush = 1'b0; s_clr_err = 1'b0;
        chk("rd_valid",     64'(s_rd_valid), 64'(rd_ok));
        chk("rd_data",      64'(s_rd_data),  64'(m_last));
        chk("level",        64'(s_level),    64'(m_lvl));
        chk("full",         64'(s_full),     64'(m_lvl == DEPTH));
        chk("empty",        64'(s_empty),    64'(m_lvl == 0));
        chk("almost_full",  64'(s_af),       64'(m_lvl >= DEPTH - 4));
        chk("almost_empty", 64'(s_ae),       64'(m_lvl <= 4));
        chk("overflow",     64'(s_ovf),      64'(m_ovf));
        chk("underflow",    64'(s_udf),      64'(m_udf));
    endtask

    task automatic model_reset();
        sb.delete();
        fq.delete();
        m_lvl = 0; m_ovf = 1'b0; m_udf = 1'b0; m_last = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        s_flush = 0; s_wr_en = 0; s_rd_en = 0; s_clr_err = 0; s_wr_data = '0;
        f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 64'(s_level), 64'd0);
        chk("rst_empty", 64'(s_empty), 64'd1);
        chk("rst_full", 64'(s_full), 64'd0);
        chk("rst_ae", 64'(s_ae), 64'd1);
        chk("rst_af", 64'(s_af), 64'd0);
        chk("rst_rd_data", 64'(s_rd_data), 64'd0);
        chk("rst_rd_valid", 64'(s_rd_valid), 64'd0);
        chk("rst_ovf", 64'(s_ovf), 64'd0);
        chk("rst_udf", 64'(s_udf), 64'd0);
        chk("rst_f_empty", 64'(f_empty), 64'd1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, overflow drops data, drain in order, underflow.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Pointer wrap-around with small bursts.
        for (int it = 0; it < 2000; it++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 32'(it * 3 + k) ^ 32'h5A00_0000, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end

        // Simultaneous read/write at level 5, then at level 0.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h7000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 32'h7100_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h7777_0001, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Flush at level 12 with overflow pending keeps the sticky error and rd_data.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0100_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 12; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h1111_2222, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h2222_3333, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // FWFT: single word appears two edges after the write.
        f_wr_en = 1'b1; f_wr_data = 32'hA5A5_A5A5; fq.push_back(f_wr_data);
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fwft_empty_n0", 64'(f_empty), 64'd1);
        @(posedge clk); #1;
        chk("fwft_empty_n1", 64'(f_empty), 64'd1);
        @(posedge clk); #1;
        chk("fwft_empty_n2", 64'(f_empty), 64'd0);
        chk("fwft_valid_n2", 64'(f_rd_valid), 64'd1);
        chk("fwft_data_n2", 64'(f_rd_data), 64'(fq.pop_front()));
        chk("fwft_level_n2", 64'(f_level), 64'd1);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        chk("fwft_pop_empty", 64'(f_empty), 64'd1);
        chk("fwft_pop_level", 64'(f_level), 64'd0);
        chk("fwft_pop_valid", 64'(f_rd_valid), 64'd0);
        chk("fwft_pop_hold", 64'(f_rd_data), 64'h0000_0000_A5A5_A5A5);

        // FWFT: pop every cycle with no bubble.
        for (int i = 0; i < 8; i++) begin
            f_wr_en = 1'b1; f_wr_data = 32'h0000_0100 + 32'(i); fq.push_back(f_wr_data);
            @(posedge clk); #1;
        end
        f_wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fwft_stream_level", 64'(f_level), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("fwft_stream_valid", 64'(f_rd_valid), 64'd1);
            chk("fwft_stream_data", 64'(f_rd_data), 64'(fq.pop_front()));
            f_rd_en = 1'b1;
            @(posedge clk); #1;
        end
        f_rd_en = 1'b0;
        chk("fwft_stream_empty", 64'(f_empty), 64'd1);
        chk("fwft_stream_level0", 64'(f_level), 64'd0);
        chk("fwft_stream_udf", 64'(f_udf), 64'd0);

        // Asynchronous reset mid-operation at level 37 with a write pending.
        for (int i = 0; i < 37; i++) step(1'b1, 32'h3700_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h3700_0099, 1'b0, 1'b0, 1'b0);
        s_wr_en = 1'b1; s_wr_data = 32'hFFFF_0000;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_level", 64'(s_level), 64'd0);
        chk("arst_empty", 64'(s_empty), 64'd1);
        chk("arst_full", 64'(s_full), 64'd0);
        chk("arst_ae", 64'(s_ae), 64'd1);
        chk("arst_rd_data", 64'(s_rd_data), 64'd0);
        chk("arst_rd_valid", 64'(s_rd_valid), 64'd0);
        chk("arst_f_rd_data", 64'(f_rd_data), 64'd0);
        s_wr_en = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        step(1'b1, 32'hC0FF_EE01, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_data_fifo_sync.md
Name: tx_data_fifo_sync

Overview:
Parametrised single-clock TX data FIFO: simple-dual-port RAM storage plus pointer, level and flag control. Generalises the fixed 1024x32 TX data buffer to any width and depth. Adds full/empty, programmable almost flags, a fill level, sticky overflow/underflow errors, synchronous flush, and an optional first-word-fall-through (FWFT) read mode. Sits between the pixel packer and the MIPI TX packet builder in the TX clock domain.

Parameters:
DW, 32, data width in bits (1..64)
AW, 10, address width; depth = 2**AW words
FWFT, 0, 0 = standard read (data 1 cycle after pop); 1 = first-word-fall-through
AF_THRESH, 2**AW-4, almost_full asserted when level >= AF_THRESH
AE_THRESH, 4, almost_empty asserted when level <= AE_THRESH

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of pointers, level and flags
wr_en  in  1  write request
wr_data  in  DW  write data
rd_en  in  1  read/pop request
rd_data  out  DW  read data
rd_valid  out  1  rd_data valid (standard: pulse; FWFT: equals !empty)
full  out  1  no space left
empty  out  1  no readable word
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  AW+1  words held (FWFT: includes output register)
overflow  out  1  sticky: wr_en while full
underflow  out  1  sticky: rd_en while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (rstn low, async): pointers=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. RAM contents undefined.
- Pointers AW+1 bits; MSB disambiguates full/empty on wrap. full = (wptr[AW-1:0]==rptr[AW-1:0]) && MSB differ.
- Write accepted iff wr_en && !full (registered full, current cycle). Read accepted iff rd_en && !empty. A read in the same cycle does not unblock a write while full; same for empty.
- All flags and level registered; update the cycle after the accepting edge. Level +1 on write only, -1 on read only, unchanged on both.
- Standard mode: accepted read at edge N gives rd_data and rd_valid=1 at N+1. rd_data holds its value while no read is accepted; rd_valid is 1 for one cycle only. Write to empty FIFO at N: empty=0 after N+1.
- FWFT mode: a 1-entry output register is prefetched from RAM. Write to empty FIFO at N: RAM read at N+1, rd_data valid and empty=0 after N+2. rd_en pops the head; next word appears the following cycle with no bubble while RAM is non-empty. rd_valid = !empty.
- overflow set on wr_en && full; underflow set on rd_en && empty. Cleared only by clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- flush: the next edge returns pointers, level, flags and rd_valid to reset values. rd_data and sticky errors are kept. flush beats wr_en/rd_en in the same cycle.
- Storage: SDP, one read port and one write port, 1-cycle read latency, no output register, no read-during-write forwarding. Control never reads an address being written in the same cycle.

Decomposition:
- Shared package tx_fifo_pkg: default DW/AW constants, level/pointer width function clog2, mode encoding constants FIFO_STD=0, FIFO_FWFT=1.
- One sub-module, tx_fifo_sdp_ram (parametrised DW/AW, inferable or mapped to EMB18K in sdp mode). All control stays in tx_data_fifo_sync.

Test Plan:
- DW=32, AW=10, STD: 1024 writes 0..1023 -> full=1 after 1024th, level=1024, almost_full from level 1020. 1025th write -> overflow=1, data dropped. 1024 reads return 0..1023 in order, then empty=1.
- Wrap-around: repeatedly write 3 then read 3 for 2000 iterations (pointer wrap) -> data order intact, level never >3, no error flags.
- Simultaneous rd_en&wr_en at level 5 for 100 cycles -> level stays 5, full/empty unchanged. Same at level 0 -> write accepted, underflow=1, level=1.
- FWFT=1: single write 0xA5A5A5A5 at edge N -> rd_data=0xA5A5A5A5, empty=0 after N+2. Pop-per-cycle stream of 8 words -> no bubbles.
- Reset mid-operation: assert rstn low at level 37 with wr_en high -> all outputs at reset values immediately (async). After release, first write/read returns the new data only.
- flush at level 12 with overflow=1 -> level=0, empty=1, overflow still 1. clr_err -> overflow=0.
